// File: rtl/mips_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM state
// encoding, transaction owner encoding and the latency counter width.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_e;

  // Wide enough for MEM_LATENCY and STARVE_LIMIT up to 15.
  localparam int LAT_W = 4;

endpackage

// File: rtl/arb_lat_counter.sv
// Memory latency countdown: loaded when the access is issued, decremented
// while waiting, and flags the cycle in which read data is on the bus.
module arb_lat_counter
  import mips_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [LAT_W-1:0] load_val_i,
  output logic             last_o
);

  logic [LAT_W-1:0] cnt_q;
  logic [LAT_W-1:0] cnt_d;

  // Next count: load takes priority, decrement stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register, cleared asynchronously so an aborted access leaves no residue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == LAT_W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port memory between instruction fetch and the data
// memory stage. DM has priority unless IF has waited through STARVE_LIMIT
// consecutive DM grants. Each transaction runs IDLE-ISSUE-WAIT..-ACK.
module mem_arbiter
  import mips_pkg::*;
#(
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ack,
  output logic        dm_stall,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [LAT_W-1:0] LAT_L    = LAT_W'(MEM_LATENCY);
  localparam logic [LAT_W-1:0] STARVE_L = LAT_W'(STARVE_LIMIT);

  arb_state_e       state_q;
  arb_owner_e       owner_q;
  logic             we_q;
  logic [LAT_W-1:0] starve_q;
  logic             mem_en_q;
  logic             mem_we_q;
  logic [31:0]      mem_addr_q;
  logic [31:0]      mem_wdata_q;
  logic [31:0]      if_rdata_q;
  logic [31:0]      dm_rdata_q;
  logic             if_ack_q;
  logic             dm_ack_q;
  logic             lat_last;

  arb_lat_counter u_lat (
    .clk        (clk),
    .rst        (reset),
    .load_i     (state_q == ISSUE),
    .dec_i      (state_q == WAIT),
    .load_val_i (LAT_L),
    .last_o     (lat_last)
  );

  // Arbiter FSM with registered memory strobes, read data and acks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      we_q        <= 1'b0;
      starve_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
    end else begin
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (dm_req && (!if_req || (starve_q < STARVE_L))) begin
            owner_q     <= OWN_DM;
            we_q        <= dm_we;
            mem_addr_q  <= dm_addr;
            mem_wdata_q <= dm_wdata;
            mem_en_q    <= 1'b1;
            mem_we_q    <= dm_we;
            state_q     <= ISSUE;
            // Count DM grants that made a waiting fetch wait longer.
            if (!if_req) begin
              starve_q <= '0;
            end else if (starve_q < STARVE_L) begin
              starve_q <= starve_q + 1'b1;
            end
          end else if (if_req) begin
            owner_q     <= OWN_IF;
            we_q        <= 1'b0;
            mem_addr_q  <= if_addr;
            mem_wdata_q <= '0;
            mem_en_q    <= 1'b1;
            state_q     <= ISSUE;
            starve_q    <= '0;
          end
        end
        ISSUE: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (lat_last) begin
            if (owner_q == OWN_IF) begin
              if_rdata_q <= mem_rdata;
              if_ack_q   <= 1'b1;
            end else begin
              if (!we_q) begin
                dm_rdata_q <= mem_rdata;
              end
              dm_ack_q <= 1'b1;
            end
            state_q <= ACK;
          end
        end
        ACK: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  // Stalls are combinational so a requester sees release in its ack cycle;
  // reset masks them so every output reads zero while reset is high.
  assign if_stall  = if_req & ~if_ack_q & ~reset;
  assign dm_stall  = dm_req & ~dm_ack_q & ~reset;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with MEM_LATENCY=2, STARVE_LIMIT=4.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        if_stall;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        dm_stall;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_tests;
  int n_fail;

  mem_arbiter #(.MEM_LATENCY(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_ack(if_ack), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: read data valid exactly 2 cycles after the mem_en cycle,
  // poison value at any other time.
  logic [31:0] mem [0:255];
  logic [31:0] d1;
  logic        d1_vld;
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA5000000 | i;
      mem[10] <= 32'h8C220004;
      mem[12] <= 32'h33334444;
      mem[64] <= 32'h11112222;
      d1_vld    <= 1'b0;
      d1        <= '0;
      mem_rdata <= 32'hBAD0BAD0;
    end else begin
      d1_vld <= mem_en && !mem_we;
      d1     <= mem[mem_addr[9:2]];
      if (mem_en && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
      mem_rdata <= d1_vld ? d1 : 32'hBAD0BAD0;
    end
  end

  task automatic test_reset();
    int acks;
    n_tests++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL rst_mem_en got %0b want 0", mem_en); end
    n_tests++; if (if_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_if_rdata got %h want 0", if_rdata); end
    n_tests++; if (dm_ack !== 1'b0) begin n_fail++; $display("FAIL rst_dm_ack got %0b want 0", dm_ack); end
    // Start a fetch, then hit reset asynchronously in its ISSUE cycle.
    if_req = 1'b1; if_addr = 32'h28;
    @(posedge clk); #3;
    n_tests++; if (mem_en !== 1'b1) begin n_fail++; $display("FAIL rst_pre_issue mem_en got %0b want 1", mem_en); end
    reset = 1'b1; #1;
    n_tests++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL rst_async_mem_en got %0b want 0", mem_en); end
    n_tests++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_async_mem_addr got %h want 0", mem_addr); end
    n_tests++; if (if_stall !== 1'b0) begin n_fail++; $display("FAIL rst_async_if_stall got %0b want 0", if_stall); end
    if_req = 1'b0;
    @(posedge clk); #1; reset = 1'b0;
    acks = 0;
    for (int k = 0; k < 6; k++) begin @(posedge clk); #1; if (if_ack) acks++; end
    n_tests++; if (acks !== 0) begin n_fail++; $display("FAIL rst_abort_no_ack got %0d acks want 0", acks); end
  endtask

  task automatic test_if_fetch();
    int ack_k, ack_cnt, en_cnt;
    logic [31:0] en_addr;
    logic stall_ok, ack_stall;
    ack_k = 0; ack_cnt = 0; en_cnt = 0; en_addr = '0; stall_ok = 1'b1; ack_stall = 1'b1;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h28;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (mem_en) begin en_cnt++; en_addr = mem_addr; end
      if (k < 4 && if_stall !== 1'b1) stall_ok = 1'b0;
      if (if_ack) begin
        ack_cnt++;
        if (ack_k == 0) begin ack_k = k; ack_stall = if_stall; end
        if_req = 1'b0;
      end
    end
    n_tests++; if (en_cnt !== 1) begin n_fail++; $display("FAIL if_mem_en_cycles got %0d want 1", en_cnt); end
    n_tests++; if (en_addr !== 32'h28) begin n_fail++; $display("FAIL if_mem_addr got %h want 00000028", en_addr); end
    n_tests++; if (ack_k !== 4) begin n_fail++; $display("FAIL if_ack_latency got %0d want 4", ack_k); end
    n_tests++; if (ack_cnt !== 1) begin n_fail++; $display("FAIL if_ack_pulses got %0d want 1", ack_cnt); end
    n_tests++; if (if_rdata !== 32'h8C220004) begin n_fail++; $display("FAIL if_rdata got %h want 8c220004", if_rdata); end
    n_tests++; if (stall_ok !== 1'b1) begin n_fail++; $display("FAIL if_stall_pending got 0 want 1"); end
    n_tests++; if (ack_stall !== 1'b0) begin n_fail++; $display("FAIL if_stall_at_ack got %0b want 0", ack_stall); end
  endtask

  task automatic test_contention();
    int dm_k, if_k;
    logic [31:0] first_addr;
    logic got_first, stall_ok;
    dm_k = 0; if_k = 0; first_addr = '0; got_first = 1'b0; stall_ok = 1'b1;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h30;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (mem_en && !got_first) begin got_first = 1'b1; first_addr = mem_addr; end
      if (if_k == 0 && !if_ack && if_stall !== 1'b1) stall_ok = 1'b0;
      if (dm_ack && dm_k == 0) begin dm_k = k; dm_req = 1'b0; end
      if (if_ack && if_k == 0) begin if_k = k; if_req = 1'b0; end
    end
    n_tests++; if (first_addr !== 32'h100) begin n_fail++; $display("FAIL cont_first_addr got %h want 00000100", first_addr); end
    n_tests++; if (dm_k !== 4) begin n_fail++; $display("FAIL cont_dm_ack_cycle got %0d want 4", dm_k); end
    n_tests++; if (if_k !== 9) begin n_fail++; $display("FAIL cont_if_ack_cycle got %0d want 9", if_k); end
    n_tests++; if (dm_rdata !== 32'h11112222) begin n_fail++; $display("FAIL cont_dm_rdata got %h want 11112222", dm_rdata); end
    n_tests++; if (if_rdata !== 32'h33334444) begin n_fail++; $display("FAIL cont_if_rdata got %h want 33334444", if_rdata); end
    n_tests++; if (stall_ok !== 1'b1) begin n_fail++; $display("FAIL cont_if_stall got 0 want 1 until ack"); end
  endtask

  task automatic test_starvation();
    logic ord [8];
    logic exp_ord [6];
    int n, dm_cnt;
    exp_ord = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) ord[i] = 1'b0;
    n = 0; dm_cnt = 0;
    @(posedge clk); #1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    if_req = 1'b1; if_addr = 32'h28;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (dm_ack && n < 8) begin
        ord[n] = 1'b1; n++; dm_cnt++;
        if (dm_cnt == 5) dm_req = 1'b0;
      end
      if (if_ack && n < 8) begin ord[n] = 1'b0; n++; if_req = 1'b0; end
    end
    n_tests++; if (n !== 6) begin n_fail++; $display("FAIL starve_ack_count got %0d want 6", n); end
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (ord[i] !== exp_ord[i]) begin
        n_fail++; $display("FAIL starve_order[%0d] got %0b want %0b (1=DM 0=IF)", i, ord[i], exp_ord[i]);
      end
    end
  endtask

  task automatic test_store();
    int ack_k, ld_k;
    logic en_we;
    logic [31:0] en_wdata, en_addr;
    ack_k = 0; ld_k = 0; en_we = 1'b0; en_wdata = '0; en_addr = '0;
    @(posedge clk); #1;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h104; dm_wdata = 32'hDEADBEEF;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (mem_en) begin en_we = mem_we; en_wdata = mem_wdata; en_addr = mem_addr; end
      if (dm_ack && ack_k == 0) begin ack_k = k; dm_req = 1'b0; dm_we = 1'b0; end
    end
    n_tests++; if (en_we !== 1'b1) begin n_fail++; $display("FAIL st_mem_we got %0b want 1", en_we); end
    n_tests++; if (en_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL st_mem_wdata got %h want deadbeef", en_wdata); end
    n_tests++; if (en_addr !== 32'h104) begin n_fail++; $display("FAIL st_mem_addr got %h want 00000104", en_addr); end
    n_tests++; if (ack_k !== 4) begin n_fail++; $display("FAIL st_dm_ack_cycle got %0d want 4", ack_k); end
    n_tests++; if (dm_rdata !== 32'h11112222) begin n_fail++; $display("FAIL st_dm_rdata_kept got %h want 11112222", dm_rdata); end
    // Read the stored word back.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h104;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (dm_ack && ld_k == 0) begin ld_k = k; dm_req = 1'b0; end
    end
    n_tests++; if (ld_k !== 4) begin n_fail++; $display("FAIL st_reload_ack_cycle got %0d want 4", ld_k); end
    n_tests++; if (dm_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL st_reload_rdata got %h want deadbeef", dm_rdata); end
  endtask

  task automatic test_reset_wait();
    int acks, ack_k;
    acks = 0; ack_k = 0;
    @(posedge clk); #1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset = 1'b1; #1;
    n_tests++; if (dm_rdata !== 32'h0) begin n_fail++; $display("FAIL rw_dm_rdata got %h want 0", dm_rdata); end
    n_tests++; if (dm_stall !== 1'b0) begin n_fail++; $display("FAIL rw_dm_stall got %0b want 0", dm_stall); end
    dm_req = 1'b0;
    @(posedge clk); #1; reset = 1'b0;
    for (int k = 0; k < 6; k++) begin @(posedge clk); #1; if (dm_ack) acks++; end
    n_tests++; if (acks !== 0) begin n_fail++; $display("FAIL rw_no_ack got %0d acks want 0", acks); end
    dm_req = 1'b1; dm_addr = 32'h30;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (dm_ack && ack_k == 0) begin ack_k = k; dm_req = 1'b0; end
    end
    n_tests++; if (ack_k !== 4) begin n_fail++; $display("FAIL rw_next_ack_cycle got %0d want 4", ack_k); end
    n_tests++; if (dm_rdata !== 32'h33334444) begin n_fail++; $display("FAIL rw_next_rdata got %h want 33334444", dm_rdata); end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_if_fetch();
    test_contention();
    test_starvation();
    test_store();
    test_reset_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 2: cycles from mem_en high to mem_rdata valid (legal range 1..15).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4: maximum consecutive DM grants while if_req is pending (legal range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port if_req  input  1  fetch-stage read request; held until if_ack.
REQ-006 SHALL have port if_addr  input  32  fetch byte address (PC).
REQ-007 SHALL have port if_rdata  output  32  instruction word returned to fetch.
REQ-008 SHALL have port if_ack  output  1  one-cycle pulse, if_rdata valid.
REQ-009 SHALL have port if_stall  output  1  fetch-stage stall.
REQ-010 SHALL have port dm_req  input  1  memory-stage request; held until dm_ack.
REQ-011 SHALL have port dm_we  input  1  1 = store, 0 = load.
REQ-012 SHALL have port dm_addr  input  32  data byte address (ALU result).
REQ-013 SHALL have port dm_wdata  input  32  store data.
REQ-014 SHALL have port dm_rdata  output  32  load data returned to memory stage.
REQ-015 SHALL have port dm_ack  output  1  one-cycle pulse, transaction complete.
REQ-016 SHALL have port dm_stall  output  1  memory-stage stall.
REQ-017 SHALL have port mem_en  output  1  single-port memory access strobe.
REQ-018 SHALL have port mem_we  output  1  memory write enable, qualified by mem_en.
REQ-019 SHALL have port mem_addr  output  32  memory address, valid while mem_en.
REQ-020 SHALL have port mem_wdata  output  32  memory write data, valid while mem_en.
REQ-021 SHALL have port mem_rdata  input  32  memory read data, valid MEM_LATENCY cycles after the mem_en cycle.

Function
REQ-022 SHALL implement FSM states IDLE, ISSUE, WAIT, ACK; requests are sampled only in IDLE.
REQ-023 In IDLE with dm_req=1 and (if_req=0 or starve_cnt<STARVE_LIMIT), SHALL grant DM; else with if_req=1, SHALL grant IF; with no request, SHALL stay in IDLE.
REQ-024 On grant, SHALL latch owner, address, we and wdata, and move to ISSUE.
REQ-025 In ISSUE, SHALL drive mem_en=1 with the latched address/we/wdata for exactly one cycle, load the latency counter with MEM_LATENCY, and move to WAIT.
REQ-026 In WAIT, SHALL decrement the counter each cycle; in the cycle where the counter equals 1, SHALL register mem_rdata into the owner's rdata (loads and IF only) and move to ACK.
REQ-027 In ACK, SHALL pulse the owner's ack for one cycle, then return to IDLE; the acked requester's req is ignored in this cycle.
REQ-028 Total latency SHALL be MEM_LATENCY+2 cycles from the sampling edge to the ack cycle; throughput is one transaction per MEM_LATENCY+3 cycles.
REQ-029 starve_cnt SHALL increment, saturating at STARVE_LIMIT, on a DM grant while if_req=1; it SHALL clear on any IF grant and on a DM grant while if_req=0.
REQ-030 if_stall SHALL equal if_req AND NOT if_ack; dm_stall SHALL equal dm_req AND NOT dm_ack.
REQ-031 Stores SHALL leave dm_rdata unchanged; if_rdata and dm_rdata SHALL hold their values between acks.
REQ-032 If a requester drops req mid-transaction, SHALL complete the transaction and still pulse ack.

Reset
REQ-033 While reset=1, SHALL force state IDLE and clear starve_cnt, the latency counter and all outputs to 0, regardless of clk.
REQ-034 Reset mid-transaction SHALL abort it: no ack is issued and returning data is discarded.

Structure
REQ-035 mips_pkg SHALL hold the arbiter state enum and the owner encoding (OWN_IF, OWN_DM).
REQ-036 The latency countdown SHALL be a sub-module arb_lat_counter (load, decrement, last-cycle flag).

Verification (MEM_LATENCY=2, STARVE_LIMIT=4)
REQ-037 Reset asserted asynchronously mid-cycle -> all outputs 0 immediately.
REQ-038 if_req with if_addr=0x28, mem_rdata=0x8C220004 -> mem_en high for exactly 1 cycle with mem_addr=0x28; if_ack 4 cycles after the sampling edge; if_rdata=0x8C220004.
REQ-039 if_req and dm_req (load 0x100) in the same cycle -> DM served first, IF granted on the next IDLE; if_stall high until its ack.
REQ-040 dm_req held for 5 loads and if_req held -> 4 DM grants, then an IF grant, then DM.
REQ-041 Store dm_addr=0x104, dm_wdata=0xDEADBEEF -> mem_en=mem_we=1, mem_wdata=0xDEADBEEF; dm_ack pulse; dm_rdata unchanged.
REQ-042 Reset during WAIT of a DM load -> IDLE, no dm_ack, next request serviced normally.
